line_clear_ctrl: RTL and testbench

- Sequencer that runs after every piece lock. It scans the block-memory board from bottom to top, removes full rows, shifts the remaining rows down and zero-fills the vacated top rows.
- Sits between the piece/cell logic and blkmemory's board array, on a dedicated read/write port.
- Touches memory only while the VGA core is not drawing (core_busy low), so the pixel-fetch path never contends with it.
- Raises busy so the movement logic holds off new requests until the pass completes.

---
 rtl/line_clear_ctrl_if.sv | 30 +++
 rtl/line_clear_ctrl.sv | 165 ++++++++++++++++
 tb/tb_line_clear_ctrl.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/line_clear_ctrl_if.sv
// Bus between the line-clear sequencer and its environment: command/status
// plus the dedicated board-memory read/write port.
interface line_clear_ctrl_if #(
  parameter int AW = 5,
  parameter int CW = 3
);
  logic          start;
  logic          core_busy;
  logic          rd_en;
  logic [AW-1:0] rd_v;
  logic [AW-1:0] rd_h;
  logic [CW-1:0] rd_data;
  logic          wr_en;
  logic [AW-1:0] wr_v;
  logic [AW-1:0] wr_h;
  logic [CW-1:0] wr_data;
  logic          busy;
  logic          done;
  logic [AW-1:0] lines_cleared;

  modport master (
    input  start, core_busy, rd_data,
    output rd_en, rd_v, rd_h, wr_en, wr_v, wr_h, wr_data, busy, done, lines_cleared
  );

  modport slave (
    output start, core_busy, rd_data,
    input  rd_en, rd_v, rd_h, wr_en, wr_v, wr_h, wr_data, busy, done, lines_cleared
  );
endinterface

// File: rtl/line_clear_ctrl.sv
// Post-lock line-clear sequencer: scans the board bottom-up, drops full rows,
// shifts survivors down and zero-fills the vacated top rows.
module line_clear_ctrl #(
  parameter int ROWS = 20,
  parameter int COLS = 10,
  parameter int AW   = 5,
  parameter int CW   = 3
) (
  input  logic clk,
  input  logic reset,
  line_clear_ctrl_if.master bus
);

  typedef enum logic [2:0] {
    IDLE, SCAN_A, SCAN_B, COPY_A, COPY_B, FILL, DONE
  } state_t;

  localparam logic [AW-1:0]        LAST_COL = AW'(COLS - 1);
  localparam logic signed [AW:0]   LAST_ROW = (AW+1)'(ROWS - 1);
  localparam logic signed [AW:0]   ONE_ROW  = (AW+1)'(1);

  state_t                state, state_n;
  logic signed [AW:0]    src, src_n, dst, dst_n;
  logic [AW-1:0]         col, col_n, count, count_n, lc, lc_n;
  logic [CW-1:0]         data, data_n;
  logic                  fresh, fresh_n;
  logic                  go_next;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      src   <= '0;
      dst   <= '0;
      col   <= '0;
      count <= '0;
      lc    <= '0;
      data  <= '0;
      fresh <= 1'b0;
    end else begin
      state <= state_n;
      src   <= src_n;
      dst   <= dst_n;
      col   <= col_n;
      count <= count_n;
      lc    <= lc_n;
      data  <= data_n;
      fresh <= fresh_n;
    end
  end

  always_comb begin
    state_n = state;
    src_n   = src;
    dst_n   = dst;
    col_n   = col;
    count_n = count;
    lc_n    = lc;
    data_n  = data;
    fresh_n = fresh;
    go_next = 1'b0;

    bus.rd_en         = 1'b0;
    bus.rd_v          = '0;
    bus.rd_h          = '0;
    bus.wr_en         = 1'b0;
    bus.wr_v          = '0;
    bus.wr_h          = '0;
    bus.wr_data       = '0;
    bus.busy          = (state != IDLE);
    bus.done          = 1'b0;
    bus.lines_cleared = lc;

    case (state)
      IDLE: if (bus.start) begin
        src_n   = LAST_ROW;
        dst_n   = LAST_ROW;
        col_n   = '0;
        count_n = '0;
        lc_n    = '0;
        state_n = SCAN_A;
      end
      SCAN_A: if (!bus.core_busy) begin
        bus.rd_en = 1'b1;
        bus.rd_v  = src[AW-1:0];
        bus.rd_h  = col;
        state_n   = SCAN_B;
      end
      SCAN_B: begin
        if (bus.rd_data == '0) begin
          if (src == dst) begin
            src_n   = src - ONE_ROW;
            dst_n   = dst - ONE_ROW;
            go_next = 1'b1;
          end else begin
            col_n   = '0;
            state_n = COPY_A;
          end
        end else if (col == LAST_COL) begin
          count_n = count + AW'(1);
          src_n   = src - ONE_ROW;
          go_next = 1'b1;
        end else begin
          col_n   = col + AW'(1);
          state_n = SCAN_A;
        end
      end
      COPY_A: if (!bus.core_busy) begin
        bus.rd_en = 1'b1;
        bus.rd_v  = src[AW-1:0];
        bus.rd_h  = col;
        fresh_n   = 1'b1;
        state_n   = COPY_B;
      end
      COPY_B: begin
        // Read data is only valid on the first COPY_B cycle; keep a copy for stalls.
        if (fresh) begin
          data_n  = bus.rd_data;
          fresh_n = 1'b0;
        end
        if (!bus.core_busy) begin
          bus.wr_en   = 1'b1;
          bus.wr_v    = dst[AW-1:0];
          bus.wr_h    = col;
          bus.wr_data = fresh ? bus.rd_data : data;
          if (col == LAST_COL) begin
            src_n   = src - ONE_ROW;
            dst_n   = dst - ONE_ROW;
            go_next = 1'b1;
          end else begin
            col_n   = col + AW'(1);
            state_n = COPY_A;
          end
        end
      end
      FILL: if (!bus.core_busy) begin
        bus.wr_en = 1'b1;
        bus.wr_v  = dst[AW-1:0];
        bus.wr_h  = col;
        if (col == LAST_COL) begin
          col_n = '0;
          dst_n = dst - ONE_ROW;
          if (dst == '0) state_n = DONE;
        end else begin
          col_n = col + AW'(1);
        end
      end
      DONE: begin
        bus.done          = 1'b1;
        bus.lines_cleared = count;
        lc_n              = count;
        state_n           = IDLE;
      end
      default: state_n = IDLE;
    endcase

    // Row-advance decision taken in the same cycle, so it costs no clock.
    if (go_next) begin
      col_n = '0;
      if (!src_n[AW])      state_n = SCAN_A;
      else if (!dst_n[AW]) state_n = FILL;
      else                 state_n = DONE;
    end
  end

endmodule

// File: tb/tb_line_clear_ctrl.sv
// Directed and randomized bench for line_clear_ctrl with a behavioural
// board model: full rows removed, survivors kept in order, zeros on top.
module tb_line_clear_ctrl;
  localparam int ROWS = 20;
  localparam int COLS = 10;
  localparam int AW   = 5;
  localparam int CW   = 3;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  line_clear_ctrl_if #(.AW(AW), .CW(CW)) bus ();
  line_clear_ctrl #(.ROWS(ROWS), .COLS(COLS), .AW(AW), .CW(CW)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  int n_assert = 0;
  int n_fail   = 0;

  logic [CW-1:0] mem    [ROWS][COLS];
  logic [CW-1:0] init_b [ROWS][COLS];
  logic [CW-1:0] exp_b  [ROWS][COLS];
  int exp_lc, exp_reads, exp_writes, exp_row0w, exp_done;
  int nreads, nwrites, row0w, ndone, done_cyc;

  logic          cap_r, cap_w;
  logic [AW-1:0] cap_rv, cap_rh, cap_wv, cap_wh;
  logic [CW-1:0] cap_wd;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic clear_init();
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) init_b[r][c] = '0;
  endtask

  // Reference: walk rows bottom-up, keep non-full rows, count cost in reads.
  task automatic prepare();
    int k, lowest, moved, fz;
    bit full;
    k = ROWS - 1; lowest = -1; moved = 0;
    exp_lc = 0; exp_reads = 0;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) mem[r][c] = init_b[r][c];
    for (int r = ROWS - 1; r >= 0; r--) begin
      fz = -1;
      for (int c = COLS - 1; c >= 0; c--) if (init_b[r][c] == 0) fz = c;
      full = (fz < 0);
      if (full) begin
        exp_lc++;
        if (lowest < 0) lowest = r;
        exp_reads += COLS;
      end else begin
        exp_reads += fz + 1;
        for (int c = 0; c < COLS; c++) exp_b[k][c] = init_b[r][c];
        k--;
        if (lowest >= 0) begin
          moved++;
          exp_reads += COLS;
        end
      end
    end
    for (int r = k; r >= 0; r--)
      for (int c = 0; c < COLS; c++) exp_b[r][c] = '0;
    exp_writes = COLS * (moved + exp_lc);
    exp_row0w  = (exp_lc > 0) ? COLS : 0;
    exp_done   = 1 + 2 * exp_reads + COLS * exp_lc;
  endtask

  task automatic capture();
    cap_r  = bus.rd_en;  cap_rv = bus.rd_v;  cap_rh = bus.rd_h;
    cap_w  = bus.wr_en;  cap_wv = bus.wr_v;  cap_wh = bus.wr_h;
    cap_wd = bus.wr_data;
  endtask

  // Memory: writes land at the edge, read data appears one cycle after rd_en.
  task automatic apply();
    @(posedge clk); #1;
    if (cap_w) begin
      check("wr_addr_range", (cap_wv < ROWS) && (cap_wh < COLS), 1);
      if (cap_wv < ROWS && cap_wh < COLS) mem[cap_wv][cap_wh] = cap_wd;
      nwrites++;
      if (cap_wv == 0) row0w++;
    end
    if (cap_r) begin
      check("rd_addr_range", (cap_rv < ROWS) && (cap_rh < COLS), 1);
      nreads++;
      bus.rd_data = (cap_rv < ROWS && cap_rh < COLS) ? mem[cap_rv][cap_rh] : 'x;
    end else begin
      bus.rd_data = CW'($urandom);
    end
  endtask

  task automatic compare_board();
    logic [COLS*CW-1:0] a, e;
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        a[c*CW +: CW] = mem[r][c];
        e[c*CW +: CW] = exp_b[r][c];
      end
      check($sformatf("board_row%0d", r), a, e);
    end
  endtask

  task automatic run_pass(input int mode, input bit pulse_again);
    int cyc;
    bit fin;
    nreads = 0; nwrites = 0; row0w = 0; ndone = 0; done_cyc = -1;
    cyc = 0; fin = 0;
    bus.core_busy = 1'b0;
    bus.start     = 1'b1;
    while (!fin && cyc < 4000) begin
      @(negedge clk);
      check("busy", bus.busy, cyc != 0);
      check("rd_wr_exclusive", bus.rd_en & bus.wr_en, 0);
      check("access_while_core_busy", bus.core_busy & (bus.rd_en | bus.wr_en), 0);
      capture();
      if (bus.done) begin
        ndone++;
        done_cyc = cyc;
        fin = 1;
        check("lines_at_done", bus.lines_cleared, exp_lc);
      end
      apply();
      bus.start = pulse_again && (cyc == 9);
      case (mode)
        0:       bus.core_busy = 1'b0;
        1:       bus.core_busy = (((cyc + 1) >> 2) & 1) != 0;
        default: bus.core_busy = ($urandom_range(0, 1) != 0);
      endcase
      cyc++;
    end
    if (!fin) check("pass_timeout", 0, 1);
    bus.start = 1'b0;
    bus.core_busy = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (bus.done) ndone++;
      check("idle_busy", bus.busy, 0);
      check("idle_lines_held", bus.lines_cleared, exp_lc);
      capture();
      apply();
    end
    check("done_pulses", ndone, 1);
    check("read_count", nreads, exp_reads);
    check("write_count", nwrites, exp_writes);
    check("row0_writes", row0w, exp_row0w);
    if (mode == 0) check("done_cycle", done_cyc, exp_done);
    compare_board();
  endtask

  initial begin
    bit found;
    reset = 1'b1;
    bus.start = 1'b0;
    bus.core_busy = 1'b0;
    bus.rd_data = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_rd_en", bus.rd_en, 0);
    check("rst_wr_en", bus.wr_en, 0);
    check("rst_lines", bus.lines_cleared, 0);
    check("rst_rd_v", bus.rd_v, 0);
    check("rst_wr_data", bus.wr_data, 0);
    reset = 1'b0;

    // Empty board
    clear_init();
    prepare();
    run_pass(0, 0);
    check("empty_done_at_41", done_cyc, 41);
    check("empty_reads", nreads, 20);
    check("empty_writes", nwrites, 0);

    // Bottom row full, one stray cell above it
    clear_init();
    for (int c = 0; c < COLS; c++) init_b[19][c] = CW'(c % 7 + 1);
    init_b[18][3] = 3'd5;
    prepare();
    check("model_one_line", exp_lc, 1);
    run_pass(0, 0);

    // Four full rows with a cell above, steady then stalled memory
    for (int m = 0; m < 2; m++) begin
      clear_init();
      for (int r = 16; r < 20; r++)
        for (int c = 0; c < COLS; c++) init_b[r][c] = CW'((r + c) % 7 + 1);
      init_b[15][0] = 3'd2;
      prepare();
      run_pass(m, 0);
      check("four_lines_r19c0", mem[19][0], 2);
    end

    // Start pulsed mid-pass is ignored
    clear_init();
    for (int c = 0; c < COLS; c++) init_b[17][c] = 3'd4;
    init_b[19][5] = 3'd1;
    init_b[12][9] = 3'd6;
    prepare();
    run_pass(0, 1);

    // Reset during the first copy write, then a clean pass on what remains
    clear_init();
    for (int c = 0; c < COLS; c++) init_b[19][c] = 3'd7;
    init_b[18][3] = 3'd5;
    prepare();
    bus.start = 1'b1;
    found = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      capture();
      if (bus.wr_en) begin
        found = 1;
        break;
      end
      apply();
      bus.start = 1'b0;
    end
    check("reached_copy_write", found, 1);
    reset = 1'b1;
    apply();
    check("midrst_busy", bus.busy, 0);
    check("midrst_wr_en", bus.wr_en, 0);
    check("midrst_done", bus.done, 0);
    check("midrst_lines", bus.lines_cleared, 0);
    reset = 1'b0;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) init_b[r][c] = mem[r][c];
    prepare();
    run_pass(0, 0);

    // Randomized boards and memory stall patterns
    for (int t = 0; t < 9; t++) begin
      for (int r = 0; r < ROWS; r++) begin
        int kind;
        kind = $urandom_range(0, 3);
        for (int c = 0; c < COLS; c++) begin
          case (kind)
            0:       init_b[r][c] = CW'($urandom_range(1, 7));
            1:       init_b[r][c] = '0;
            default: init_b[r][c] = ($urandom_range(0, 3) == 0) ? '0 : CW'($urandom_range(1, 7));
          endcase
        end
      end
      prepare();
      run_pass(t % 3, t == 4);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
